dnn_accel_system_sw_pio: RTL and testbench



---
 rtl/dnn_accel_system_sw_pio_pkg.sv | 21 ++
 rtl/dnn_accel_system_sw_pio_debounce_bit.sv | 60 ++++++
 rtl/dnn_accel_system_sw_pio.sv | 101 ++++++++++
 tb/tb_dnn_accel_system_sw_pio.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dnn_accel_system_sw_pio_pkg.sv
// Shared definitions for the dnn_accel_system switch/key input PIO.
// Holds the register address map and the encodings of the EDGE_TYPE
// parameter that selects which debounced transitions are captured.
package dnn_accel_system_sw_pio_pkg;

  // Register address map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Width of the per-bit debounce counter
  function automatic int deb_cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/dnn_accel_system_sw_pio_debounce_bit.sv
// One input bit of the switch/key PIO: two-flop synchronizer followed by a
// debounce counter and the debounced output flop.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in_bit   asynchronous external input
//   deb      debounced, clk-synchronous value
import dnn_accel_system_sw_pio_pkg::*;

module sw_pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic deb
);

  localparam int CNT_W = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             deb_q,   deb_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = in_bit;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    // Any sample agreeing with the debounced value restarts the count, so
    // only an uninterrupted run of DEBOUNCE_CYCLES differing samples flips deb.
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/dnn_accel_system_sw_pio.sv
// Avalon-MM slave input PIO for the dnn_accel_system switches and keys.
// Each in_port bit is synchronized and debounced; selected debounced edges
// are latched in a sticky write-1-to-clear capture register, and irq is
// raised while any captured edge is enabled by the mask register.
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   address, chipselect,   register interface; write when chipselect=1
//   write_n, writedata     and write_n=0 on a clk edge
//   readdata               zero-extended register selected by address
//   in_port                external asynchronous inputs
//   irq                    active-high level interrupt
import dnn_accel_system_sw_pio_pkg::*;

module dnn_accel_system_sw_pio #(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] deb;
  logic [DATA_WIDTH-1:0] deb_dly_q,  deb_dly_d;
  logic [DATA_WIDTH-1:0] mask_q,     mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] edge_set;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic                  wr_en;

  // Only the low DATA_WIDTH bits of writedata are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    sw_pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .in_bit (in_port[i]),
      .deb    (deb[i])
    );
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_set = ~deb & deb_dly_q;
      EDGE_ANY:  edge_set =  deb ^ deb_dly_q;
      default:   edge_set =  deb & ~deb_dly_q;
    endcase
  end

  always_comb begin
    deb_dly_d  = deb;
    mask_d     = mask_q;
    edge_clr   = '0;
    if (wr_en && address == ADDR_MASK) begin
      mask_d = writedata[DATA_WIDTH-1:0];
    end
    if (wr_en && address == ADDR_EDGE) begin
      edge_clr = writedata[DATA_WIDTH-1:0];
    end
    // Set is OR-ed in after the clear so a simultaneous new edge is kept.
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q  <= '0;
      mask_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      deb_dly_q  <= deb_dly_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    case (address)
      ADDR_DATA: readdata = 32'(deb);
      ADDR_MASK: readdata = 32'(mask_q);
      ADDR_EDGE: readdata = 32'(edge_cap_q);
      default:   readdata = 32'd0;
    endcase
  end

  // Built purely from flops, so no combinational path from in_port or the bus.
  assign irq = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_dnn_accel_system_sw_pio.sv
module tb_dnn_accel_system_sw_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [7:0]  in_port2;
  logic [31:0] readdata, readdata_f, readdata_a;
  logic        irq, irq_f, irq_a;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dnn_accel_system_sw_pio #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));

  dnn_accel_system_sw_pio #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_f),
    .in_port(in_port2), .irq(irq_f));

  dnn_accel_system_sw_pio #(.DATA_WIDTH(8), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port2), .irq(irq_a));

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic check_all_zero(input string name);
    logic [31:0] d;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      check($sformatf("%s_addr%0d", name, a), d, 32'h0);
    end
    check({name, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;

    tbl[0]  = '{1'b0, 2'd2, 32'h0,        32'h05, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 32'h0,        32'h00, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 32'h04,       32'h00, 1'b1};
    tbl[3]  = '{1'b0, 2'd1, 32'h0,        32'h04, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 32'h04,       32'h00, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 32'h0,        32'h01, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 32'hFFFFFFFF, 32'h00, 1'b1};
    tbl[7]  = '{1'b0, 2'd1, 32'h0,        32'hFF, 1'b1};
    tbl[8]  = '{1'b1, 2'd0, 32'hFFFFFFFF, 32'h00, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 32'hFFFFFFFF, 32'h00, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 32'h0,        32'h05, 1'b1};
    tbl[11] = '{1'b0, 2'd3, 32'h0,        32'h00, 1'b1};
    tbl[12] = '{1'b0, 2'd2, 32'h0,        32'h01, 1'b1};
    tbl[13] = '{1'b1, 2'd2, 32'hFFFFFFFF, 32'h00, 1'b0};
    tbl[14] = '{1'b0, 2'd2, 32'h0,        32'h00, 1'b0};
    tbl[15] = '{1'b1, 2'd1, 32'h0,        32'h00, 1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;
    in_port2   = 8'h00;
    cyc(3);
    reset_n = 1'b1;
    check_all_zero("reset");

    // 10-cycle glitch on bit 0 must be rejected
    in_port = 8'h01;
    cyc(10);
    in_port = 8'h00;
    cyc(30);
    rd(2'd0, d); check("glitch_data", d, 32'h00);
    rd(2'd2, d); check("glitch_edge", d, 32'h00);

    // Held input: DATA after exactly 18 cycles, EDGE one cycle later
    in_port = 8'h01;
    cyc(17);
    rd(2'd0, d); check("accept_data_17", d, 32'h00);
    cyc();
    rd(2'd0, d); check("accept_data_18", d, 32'h01);
    rd(2'd2, d); check("accept_edge_18", d, 32'h00);
    cyc();
    rd(2'd2, d); check("accept_edge_19", d, 32'h01);

    // Bit 2 rises so EDGE becomes 0x05 for the register table
    in_port = 8'h05;
    cyc(20);
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].wdata);
      end else begin
        rd(tbl[i].addr, d);
        check($sformatf("tbl%0d_rd", i), d, tbl[i].exp_rd);
      end
      check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // Set/clear collision on bit 0: W1C lands on the edge that sets it
    in_port = 8'h04;
    cyc(25);
    rd(2'd2, d); check("coll_pre_edge", d, 32'h00);
    in_port = 8'h05;
    cyc(18);
    rd(2'd0, d); check("coll_data", d, 32'h05);
    rd(2'd2, d); check("coll_edge_before", d, 32'h00);
    wr(2'd2, 32'h01);
    rd(2'd2, d); check("coll_set_wins", d, 32'h01);

    // Mid-activity reset with a partial debounce in flight
    wr(2'd1, 32'hFF);
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    in_port = 8'h04;
    cyc(8);
    rd(2'd0, d); check("pre_reset_data", d, 32'h05);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    in_port = 8'h01;
    cyc(2);
    reset_n = 1'b1;
    cyc(10);
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(17);
    rd(2'd0, d); check("rerelease_data_17", d, 32'h00);
    cyc();
    rd(2'd0, d); check("rerelease_data_18", d, 32'h01);
    cyc();
    rd(2'd2, d); check("rerelease_edge_19", d, 32'h01);
    check("rerelease_mask", {31'd0, irq}, 32'd0);

    // EDGE_TYPE 1 and 2 instances
    in_port2 = 8'hFF;
    cyc(25);
    wr(2'd2, 32'hFF);
    address = 2'd2; #1;
    check("t1_cleared", readdata_f, 32'h00);
    check("t2_cleared", readdata_a, 32'h00);
    in_port2 = 8'h00;
    cyc(25);
    address = 2'd2; #1;
    check("t1_fall_edge", readdata_f, 32'hFF);
    check("t2_fall_edge", readdata_a, 32'hFF);
    wr(2'd2, 32'hFF);
    in_port2 = 8'hFF;
    cyc(25);
    address = 2'd2; #1;
    check("t1_rise_edge", readdata_f, 32'h00);
    check("t2_rise_edge", readdata_a, 32'hFF);
    address = 2'd0; #1;
    check("t1_data", readdata_f, 32'hFF);
    check("t2_data", readdata_a, 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
